cdb_arbiter: RTL and testbench

- Shares the two RoB completion ports (finish port 0 / port 1) between N_REQ functional-unit requesters (ALU RS, LSB, branch unit, ...).
- Each requester has its own small FIFO. Up to two results per cycle are picked round-robin and driven, registered, onto the two CDB broadcast ports.
- Those ports feed both the ReorderBuffer finish inputs and the RS/LSB operand-snoop logic.
- Sits between the execution units and the ReorderBuffer; honours the RoB flush signal.

---
 rtl/cdb_arbiter_pkg.sv | 11 +
 rtl/cdb_fifo.sv | 63 ++++++
 rtl/cdb_arbiter.sv | 145 ++++++++++++++
 tb/tb_cdb_arbiter.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdb_arbiter_pkg.sv
// Shared constants for the CDB arbiter: RoB id width, broadcast port count
// and the default per-requester queue depth.
package cdb_arbiter_pkg;

    localparam int ROB_BITS   = 5;
    localparam int ROB_SIZE   = 1 << ROB_BITS;
    localparam int CDB_PORTS  = 2;
    localparam int CDB_QDEPTH = 2;
    localparam int DATA_W     = 32;

endpackage

// File: rtl/cdb_fifo.sv
// Single-requester result queue holding {RoB id, value} entries. Push, pop
// and flush only take effect on an edge with rdy_in high; flush wins.
module cdb_fifo
    import cdb_arbiter_pkg::*;
#(
    parameter int BITS   = ROB_BITS,
    parameter int QDEPTH = CDB_QDEPTH,
    localparam int AW    = $clog2(QDEPTH),
    localparam int CNT_W = AW + 1
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              flush,
    input  logic              push,
    input  logic [BITS-1:0]   push_id,
    input  logic [DATA_W-1:0] push_value,
    input  logic              pop,
    output logic [BITS-1:0]   head_id,
    output logic [DATA_W-1:0] head_value,
    output logic [CNT_W-1:0]  count,
    output logic              full
);

    logic [BITS-1:0]   mem_id    [QDEPTH];
    logic [DATA_W-1:0] mem_value [QDEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;

    // Pointer and occupancy bookkeeping; pointers wrap naturally mod QDEPTH.
    always_ff @(posedge clk_in or posedge rst_in) begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values.
        if (rst_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (rdy_in) begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                count <= count + CNT_W'(push) - CNT_W'(pop);
            end
        end
    end

    // Entry storage written at the tail.
    always_ff @(posedge clk_in) begin
        // NOTE: storage is not reset; empty slots are never read because count guards them.
        if (rdy_in && !flush && push) begin
            mem_id[wr_ptr]    <= push_id;
            mem_value[wr_ptr] <= push_value;
        end
    end

    assign head_id    = mem_id[rd_ptr];
    assign head_value = mem_value[rd_ptr];
    assign full       = (count == CNT_W'(QDEPTH));

endmodule

// File: rtl/cdb_arbiter.sv
// Shares the two CDB broadcast ports between N_REQ functional units. Each
// requester owns a small queue; up to two heads per cycle are picked
// round-robin and registered onto the CDB ports.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int BITS   = ROB_BITS,
    parameter int N_REQ  = 3,
    parameter int QDEPTH = CDB_QDEPTH
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    rdy_in,
    input  logic                    clear_in,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*BITS-1:0]   req_id,
    input  logic [N_REQ*DATA_W-1:0] req_value,
    output logic [N_REQ-1:0]        req_ready,
    output logic                    cdb0_rdy,
    output logic [BITS-1:0]         cdb0_id,
    output logic [DATA_W-1:0]       cdb0_value,
    output logic                    cdb1_rdy,
    output logic [BITS-1:0]         cdb1_id,
    output logic [DATA_W-1:0]       cdb1_value
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(QDEPTH) + 1;

    logic [N_REQ-1:0]  fifo_full;
    logic [N_REQ-1:0]  fifo_empty;
    logic [N_REQ-1:0]  push;
    logic [N_REQ-1:0]  pop;
    logic [CNT_W-1:0]  fifo_count [N_REQ];
    logic [BITS-1:0]   head_id    [N_REQ];
    logic [DATA_W-1:0] head_value [N_REQ];

    logic [PTR_W-1:0]  rr_ptr;
    logic [PTR_W-1:0]  rr_next;
    logic [PTR_W-1:0]  last_idx;
    logic [PTR_W-1:0]  scan_pos;
    int                scan_idx;
    logic              gnt0_vld;
    logic              gnt1_vld;
    logic [PTR_W-1:0]  gnt0_idx;
    logic [PTR_W-1:0]  gnt1_idx;

    // Acceptance depends only on registered occupancy, never on a same-cycle pop.
    assign req_ready = ~fifo_full;
    assign push      = req_valid & req_ready;

    for (genvar r = 0; r < N_REQ; r++) begin : g_fifo
        cdb_fifo #(
            .BITS   (BITS),
            .QDEPTH (QDEPTH)
        ) u_fifo (
            .clk_in     (clk_in),
            .rst_in     (rst_in),
            .rdy_in     (rdy_in),
            .flush      (clear_in),
            .push       (push[r]),
            .push_id    (req_id[r*BITS +: BITS]),
            .push_value (req_value[r*DATA_W +: DATA_W]),
            .pop        (pop[r]),
            .head_id    (head_id[r]),
            .head_value (head_value[r]),
            .count      (fifo_count[r]),
            .full       (fifo_full[r])
        );
        assign fifo_empty[r] = (fifo_count[r] == '0);
    end

    // Two-winner round-robin scan starting at rr_ptr, plus pop and pointer update.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
        gnt0_vld = 1'b0;
        gnt1_vld = 1'b0;
        gnt0_idx = '0;
        gnt1_idx = '0;
        scan_idx = 0;
        scan_pos = '0;
        last_idx = rr_ptr;
        rr_next  = rr_ptr;
        pop      = '0;

        for (int k = 0; k < N_REQ; k++) begin
            scan_idx = int'(rr_ptr) + k;
            if (scan_idx >= N_REQ) scan_idx = scan_idx - N_REQ;
            scan_pos = PTR_W'(scan_idx);
            if (!fifo_empty[scan_pos]) begin
                if (!gnt0_vld) begin
                    gnt0_vld = 1'b1;
                    gnt0_idx = scan_pos;
                end else if (!gnt1_vld) begin
                    gnt1_vld = 1'b1;
                    gnt1_idx = scan_pos;
                end
            end
        end

        for (int r = 0; r < N_REQ; r++) begin
            pop[r] = (gnt0_vld && gnt0_idx == PTR_W'(r)) ||
                     (gnt1_vld && gnt1_idx == PTR_W'(r));
        end

        if (gnt1_vld)      last_idx = gnt1_idx;
        else if (gnt0_vld) last_idx = gnt0_idx;

        if (gnt0_vld) begin
            rr_next = (last_idx == PTR_W'(N_REQ - 1)) ? '0 : last_idx + 1'b1;
        end
    end

    // Registered broadcast ports and round-robin pointer; ungranted ports keep id/value.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            rr_ptr     <= '0;
            cdb0_rdy   <= 1'b0;
            cdb0_id    <= '0;
            cdb0_value <= '0;
            cdb1_rdy   <= 1'b0;
            cdb1_id    <= '0;
            cdb1_value <= '0;
        end else if (rdy_in) begin
            if (clear_in) begin
                rr_ptr   <= '0;
                cdb0_rdy <= 1'b0;
                cdb1_rdy <= 1'b0;
            end else begin
                rr_ptr   <= rr_next;
                cdb0_rdy <= gnt0_vld;
                cdb1_rdy <= gnt1_vld;
                if (gnt0_vld) begin
                    cdb0_id    <= head_id[gnt0_idx];
                    cdb0_value <= head_value[gnt0_idx];
                end
                if (gnt1_vld) begin
                    cdb1_id    <= head_id[gnt1_idx];
                    cdb1_value <= head_value[gnt1_idx];
                end
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: queue-based reference model compared
// every cycle, directed scenarios with literal expectations, random traffic.
module tb_cdb_arbiter;

    localparam int BITS   = 5;
    localparam int N_REQ  = 3;
    localparam int QDEPTH = 2;

    logic                  clk_in = 1'b0;
    logic                  rst_in = 1'b1;
    logic                  rdy_in = 1'b1;
    logic                  clear_in = 1'b0;
    logic [N_REQ-1:0]      req_valid = '0;
    logic [N_REQ*BITS-1:0] req_id = '0;
    logic [N_REQ*32-1:0]   req_value = '0;
    logic [N_REQ-1:0]      req_ready;
    logic                  cdb0_rdy, cdb1_rdy;
    logic [BITS-1:0]       cdb0_id, cdb1_id;
    logic [31:0]           cdb0_value, cdb1_value;

    cdb_arbiter #(.BITS(BITS), .N_REQ(N_REQ), .QDEPTH(QDEPTH)) dut (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .rdy_in     (rdy_in),
        .clear_in   (clear_in),
        .req_valid  (req_valid),
        .req_id     (req_id),
        .req_value  (req_value),
        .req_ready  (req_ready),
        .cdb0_rdy   (cdb0_rdy),
        .cdb0_id    (cdb0_id),
        .cdb0_value (cdb0_value),
        .cdb1_rdy   (cdb1_rdy),
        .cdb1_id    (cdb1_id),
        .cdb1_value (cdb1_value)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;
    bit started = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [BITS-1:0] id;
        logic [31:0]     value;
    } entry_t;

    entry_t          q [N_REQ][$];
    int              m_rr;
    logic            m_rdy0, m_rdy1;
    logic [BITS-1:0] m_id0, m_id1;
    logic [31:0]     m_val0, m_val1;

    always @(posedge clk_in or posedge rst_in) begin
        int w0, w1, nw, idx;
        bit acc [N_REQ];
        entry_t e;
        if (rst_in) begin
            for (int r = 0; r < N_REQ; r++) q[r].delete();
            m_rr = 0;
            m_rdy0 = 0; m_rdy1 = 0;
            m_id0 = '0; m_id1 = '0; m_val0 = '0; m_val1 = '0;
        end else if (rdy_in) begin
            if (clear_in) begin
                for (int r = 0; r < N_REQ; r++) q[r].delete();
                m_rr = 0;
                m_rdy0 = 0; m_rdy1 = 0;
            end else begin
                nw = 0; w0 = 0; w1 = 0;
                for (int k = 0; k < N_REQ; k++) begin
                    idx = (m_rr + k) % N_REQ;
                    if (q[idx].size() > 0) begin
                        if (nw == 0) w0 = idx;
                        else if (nw == 1) w1 = idx;
                        if (nw < 2) nw++;
                    end
                end
                for (int r = 0; r < N_REQ; r++)
                    acc[r] = req_valid[r] && (q[r].size() < QDEPTH);
                m_rdy0 = (nw >= 1);
                m_rdy1 = (nw >= 2);
                if (nw >= 1) begin
                    e = q[w0].pop_front();
                    m_id0 = e.id; m_val0 = e.value;
                end
                if (nw >= 2) begin
                    e = q[w1].pop_front();
                    m_id1 = e.id; m_val1 = e.value;
                end
                if (nw == 1) m_rr = (w0 + 1) % N_REQ;
                if (nw == 2) m_rr = (w1 + 1) % N_REQ;
                for (int r = 0; r < N_REQ; r++) begin
                    if (acc[r]) begin
                        e.id    = req_id[r*BITS +: BITS];
                        e.value = req_value[r*32 +: 32];
                        q[r].push_back(e);
                    end
                end
            end
        end
    end

    function automatic logic [N_REQ-1:0] m_ready();
        logic [N_REQ-1:0] v;
        for (int r = 0; r < N_REQ; r++) v[r] = (q[r].size() < QDEPTH);
        return v;
    endfunction

    // Per-cycle comparison, away from the active edge.
    always @(negedge clk_in) begin
        if (started && !rst_in) begin
            check("req_ready", req_ready, m_ready());
            check("cdb0_rdy", cdb0_rdy, m_rdy0);
            check("cdb0_id", cdb0_id, m_id0);
            check("cdb0_value", cdb0_value, m_val0);
            check("cdb1_rdy", cdb1_rdy, m_rdy1);
            check("cdb1_id", cdb1_id, m_id1);
            check("cdb1_value", cdb1_value, m_val1);
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk_in);
        #1;
    endtask

    task automatic set_req(input int r, input logic [BITS-1:0] id, input logic [31:0] val);
        req_valid[r]             = 1'b1;
        req_id[r*BITS +: BITS]   = id;
        req_value[r*32 +: 32]    = val;
    endtask

    logic [N_REQ-1:0] was_ready;
    bit               bp_seen;
    logic [BITS-1:0]  next_id0;

    initial begin
        rst_in = 1'b1;
        cyc(); cyc();
        rst_in = 1'b0;
        started = 1;
        check("ready_after_reset", req_ready, 3'b111);
        check("cdb0_rdy_after_reset", cdb0_rdy, 1'b0);
        check("cdb0_id_after_reset", cdb0_id, '0);

        // Single request from requester 1.
        set_req(1, 5'd5, 32'h1234);
        cyc(); req_valid = '0;
        check("single_c1_rdy0", cdb0_rdy, 1'b0);
        cyc();
        check("single_c2_rdy0", cdb0_rdy, 1'b1);
        check("single_c2_id0", cdb0_id, 5'd5);
        check("single_c2_val0", cdb0_value, 32'h1234);
        check("single_c2_rdy1", cdb1_rdy, 1'b0);
        cyc();
        check("single_c3_rdy0", cdb0_rdy, 1'b0);
        check("single_c3_rdy1", cdb1_rdy, 1'b0);

        // Three-way contention from rr_ptr = 0 (forced by a clear).
        clear_in = 1'b1; cyc(); clear_in = 1'b0;
        set_req(0, 5'd1, 32'h11); set_req(1, 5'd2, 32'h22); set_req(2, 5'd3, 32'h33);
        cyc(); req_valid = '0;
        cyc();
        check("three_c2_rdy0", cdb0_rdy, 1'b1);
        check("three_c2_id0", cdb0_id, 5'd1);
        check("three_c2_rdy1", cdb1_rdy, 1'b1);
        check("three_c2_id1", cdb1_id, 5'd2);
        cyc();
        check("three_c3_rdy0", cdb0_rdy, 1'b1);
        check("three_c3_id0", cdb0_id, 5'd3);
        check("three_c3_rdy1", cdb1_rdy, 1'b0);
        // rr_ptr back at 0: requester 0 must take port 0 ahead of requester 1.
        set_req(1, 5'd9, 32'h99); set_req(0, 5'd8, 32'h88);
        cyc(); req_valid = '0;
        cyc();
        check("rr_zero_id0", cdb0_id, 5'd8);
        check("rr_zero_id1", cdb1_id, 5'd9);
        cyc(); cyc();

        // Backpressure: requester 0 pushes every cycle against heavy traffic.
        bp_seen = 0;
        next_id0 = 5'd0;
        for (int n = 0; n < 60; n++) begin
            set_req(0, next_id0, {27'h0, next_id0});
            for (int r = 1; r < N_REQ; r++) begin
                if ($urandom_range(0, 9) < 8) set_req(r, BITS'($urandom), $urandom);
                else req_valid[r] = 1'b0;
            end
            was_ready = req_ready;
            cyc();
            if (was_ready[0]) next_id0 = next_id0 + 1'b1;
            if (!req_ready[0]) bp_seen = 1;
        end
        req_valid = '0;
        check("backpressure_seen", bp_seen, 1'b1);
        repeat (6) cyc();

        // Flush mid-stream with a simultaneous push.
        set_req(0, 5'd20, 32'h20); set_req(1, 5'd21, 32'h21); set_req(2, 5'd22, 32'h22);
        cyc();
        set_req(0, 5'd23, 32'h23); set_req(1, 5'd24, 32'h24); set_req(2, 5'd25, 32'h25);
        cyc();
        clear_in = 1'b1;
        set_req(0, 5'd26, 32'h26); set_req(1, 5'd27, 32'h27); set_req(2, 5'd28, 32'h28);
        cyc();
        clear_in = 1'b0; req_valid = '0;
        check("flush_rdy0", cdb0_rdy, 1'b0);
        check("flush_rdy1", cdb1_rdy, 1'b0);
        check("flush_ready", req_ready, 3'b111);
        cyc();
        check("flush_after1_rdy0", cdb0_rdy, 1'b0);
        check("flush_after1_rdy1", cdb1_rdy, 1'b0);
        cyc();
        check("flush_after2_rdy0", cdb0_rdy, 1'b0);

        // Pause while an entry sits on port 0.
        set_req(2, 5'd7, 32'hABCD);
        cyc(); req_valid = '0;
        cyc();
        check("pause_pre_rdy0", cdb0_rdy, 1'b1);
        rdy_in = 1'b0;
        for (int n = 0; n < 3; n++) begin
            req_valid = (n % 2 == 0) ? 3'b111 : 3'b000;
            cyc();
            check("pause_hold_rdy0", cdb0_rdy, 1'b1);
            check("pause_hold_id0", cdb0_id, 5'd7);
            check("pause_hold_val0", cdb0_value, 32'hABCD);
        end
        rdy_in = 1'b1; req_valid = '0;
        cyc();
        check("pause_resume_rdy0", cdb0_rdy, 1'b0);
        cyc();
        check("pause_no_push_rdy0", cdb0_rdy, 1'b0);
        check("pause_no_push_rdy1", cdb1_rdy, 1'b0);

        // Asynchronous reset with queues full and outputs live.
        set_req(0, 5'd12, 32'h12); set_req(1, 5'd13, 32'h13); set_req(2, 5'd14, 32'h14);
        cyc(); cyc(); cyc();
        req_valid = '0;
        #2 rst_in = 1'b1;
        #1;
        check("async_rst_rdy0", cdb0_rdy, 1'b0);
        check("async_rst_id0", cdb0_id, '0);
        check("async_rst_val0", cdb0_value, '0);
        check("async_rst_rdy1", cdb1_rdy, 1'b0);
        cyc();
        rst_in = 1'b0;
        check("rst_release_ready", req_ready, 3'b111);
        set_req(1, 5'd17, 32'h17);
        cyc(); req_valid = '0;
        check("rst_new_c1_rdy0", cdb0_rdy, 1'b0);
        cyc();
        check("rst_new_c2_rdy0", cdb0_rdy, 1'b1);
        check("rst_new_c2_id0", cdb0_id, 5'd17);

        // Random traffic with pauses and occasional flushes; requests held until taken.
        for (int n = 0; n < 3000; n++) begin
            was_ready = req_ready;
            for (int r = 0; r < N_REQ; r++) begin
                if (!(req_valid[r] && !was_ready[r])) begin
                    if ($urandom_range(0, 9) < 6) set_req(r, BITS'($urandom), $urandom);
                    else req_valid[r] = 1'b0;
                end
            end
            rdy_in   = ($urandom_range(0, 9) != 0);
            clear_in = ($urandom_range(0, 49) == 0);
            cyc();
        end
        rdy_in = 1'b1; clear_in = 1'b0; req_valid = '0;
        repeat (10) cyc();
        check("drain_rdy0", cdb0_rdy, 1'b0);
        check("drain_ready", req_ready, 3'b111);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
